ascii_dec_parser: RTL

//  Converts a newline-terminated ASCII decimal line into an unsigned binary word.

---
 rtl/ascii_dec_parser.sv | 229 ++++++++++++++++++++++
 1 files changed

// File: rtl/ascii_dec_parser.sv
// ascii_dec_parser
// Converts a newline-terminated ASCII decimal line into a binary word and
// holds the result (value/err/digits) until the consumer acknowledges it.
// Optional feature: define SIGNED_INPUT_EN to accept a leading '-' and
// produce a two's complement result with signed magnitude limits.
//
// state | meaning
// IDLE  | waiting for first significant byte of a line
// ACCUM | accumulating decimal digits
// DRAIN | bad character seen, swallowing bytes until '\n'
// DONE  | result presented, waiting for out_ack

module ascii_dec_parser #(
    parameter int WIDTH      = 32,
    parameter int MAX_DIGITS = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_vld,
    input  logic [7:0]       in_data,
    output logic             in_rdy,
    output logic             out_vld,
    input  logic             out_ack,
    output logic [WIDTH-1:0] value,
    output logic [1:0]       err,
    output logic [3:0]       digits,
    output logic             dropped
);

    localparam logic [7:0] CH_LF    = 8'h0A;
    localparam logic [7:0] CH_CR    = 8'h0D;
    localparam logic [7:0] CH_SP    = 8'h20;
    localparam logic [7:0] CH_MINUS = 8'h2D;

    localparam logic [1:0] ERR_OK    = 2'd0;
    localparam logic [1:0] ERR_OVF   = 2'd1;
    localparam logic [1:0] ERR_BAD   = 2'd2;
    localparam logic [1:0] ERR_EMPTY = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic [WIDTH-1:0] acc;
    logic [3:0]       cnt;
    logic             ovf;
    logic             bad;
    logic             neg;

    logic [WIDTH-1:0] value_q;
    logic [1:0]       err_q;
    logic [3:0]       digits_q;
    logic             dropped_q;

    logic             take;
    logic             is_digit;
    logic             is_minus;
    logic             minus_ok;
    logic [3:0]       dval;
    logic [WIDTH+3:0] ext;
    logic [WIDTH+3:0] prod;
    logic [WIDTH+3:0] lim;
    logic             dig_ovf;
    logic             mag_ovf;
    logic             step_ovf;
    logic [1:0]       err_nxt;
    logic [WIDTH-1:0] val_nxt;

    // byte decode and next-digit arithmetic
    always_comb begin
        take     = in_vld && in_rdy;
        is_digit = (in_data >= 8'h30) && (in_data <= 8'h39);
        is_minus = (in_data == CH_MINUS);
        dval     = in_data[3:0];
        ext      = {4'b0000, acc};
        // acc*10 as two shifts; the 4 spare bits catch any carry out of WIDTH
        prod     = (ext << 3) + (ext << 1) + {{WIDTH{1'b0}}, dval};
`ifdef SIGNED_INPUT_EN
        minus_ok = 1'b1;
        lim      = {{(WIDTH+3){1'b0}}, 1'b1} << (WIDTH - 1);
        if (!neg) begin
            lim = lim - {{(WIDTH+3){1'b0}}, 1'b1};
        end
`else
        minus_ok = 1'b0;
        lim      = {4'b0000, {WIDTH{1'b1}}};
`endif
        mag_ovf  = (prod > lim);
        dig_ovf  = ((int'(cnt) + 1) > MAX_DIGITS);
        step_ovf = mag_ovf || dig_ovf;
    end

    // result seen at '\n': bad > ovf > empty > ok, value forced to 0 on error
    always_comb begin
        if (bad || (state == DRAIN)) begin
            err_nxt = ERR_BAD;
        end else if (ovf) begin
            err_nxt = ERR_OVF;
        end else if (cnt == 4'd0) begin
            err_nxt = ERR_EMPTY;
        end else begin
            err_nxt = ERR_OK;
        end
        if (err_nxt != ERR_OK) begin
            val_nxt = '0;
        end else if (neg) begin
            val_nxt = ~acc + {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            val_nxt = acc;
        end
    end

    // state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (take) begin
                    if (is_digit) begin
                        state_nxt = ACCUM;
                    end else if ((in_data == CH_CR) || (in_data == CH_SP)) begin
                        state_nxt = IDLE;
                    end else if (in_data == CH_LF) begin
                        state_nxt = DONE;
                    end else if (is_minus && minus_ok) begin
                        state_nxt = ACCUM;
                    end else begin
                        state_nxt = DRAIN;
                    end
                end
            end
            ACCUM: begin
                if (take) begin
                    if (is_digit || (in_data == CH_CR)) begin
                        state_nxt = ACCUM;
                    end else if (in_data == CH_LF) begin
                        state_nxt = DONE;
                    end else begin
                        state_nxt = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (take && (in_data == CH_LF)) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (out_ack) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // handshake outputs decoded from the state register
    always_comb begin
        in_rdy  = (state != DONE);
        out_vld = (state == DONE);
    end

    // accumulator, flags and held result
    always_ff @(posedge clk) begin
        if (rst) begin
            acc       <= '0;
            cnt       <= 4'd0;
            ovf       <= 1'b0;
            bad       <= 1'b0;
            neg       <= 1'b0;
            value_q   <= '0;
            err_q     <= ERR_OK;
            digits_q  <= 4'd0;
            dropped_q <= 1'b0;
        end else begin
            if (in_vld && !in_rdy) begin
                dropped_q <= 1'b1;
            end
            if (take && is_digit && ((state == IDLE) || (state == ACCUM))) begin
                if (cnt != 4'hF) begin
                    cnt <= cnt + 4'd1;
                end
                if (step_ovf) begin
                    ovf <= 1'b1;
                end else if (!ovf) begin
                    acc <= prod[WIDTH-1:0];
                end
            end
            if (take && is_minus && minus_ok && (state == IDLE)) begin
                neg <= 1'b1;
            end
            if ((state_nxt == DRAIN) && (state != DRAIN)) begin
                bad <= 1'b1;
            end
            if (take && (in_data == CH_LF)) begin
                value_q  <= val_nxt;
                err_q    <= err_nxt;
                digits_q <= cnt;
            end
            if ((state == DONE) && out_ack) begin
                acc <= '0;
                cnt <= 4'd0;
                ovf <= 1'b0;
                bad <= 1'b0;
                neg <= 1'b0;
            end
        end
    end

    assign value   = value_q;
    assign err     = err_q;
    assign digits  = digits_q;
    assign dropped = dropped_q;

endmodule
